// File: rtl/gen_pipe_pkg.sv
// Shared helpers for the pipe sink: counter/pointer sizing and wrapping pointer increment.
// Pure functions only; no state, no latency, no flow control.
// Pointers wrap by explicit compare so depths that are not powers of two work.
package gen_pipe_pkg;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to address n entries; a single-entry buffer still gets one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/gen_pipe_sink_crd.sv
// Credit counter for the pipe sink: one credit per free landing-buffer slot.
// crd_avl is combinational from the count register; count updates one cycle after take/ret.
// A take with no credit is ignored (flagged on err_crd when GEN_PIPE_SINK_ERR_EN is defined).
module gen_pipe_sink_crd
    import gen_pipe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic take_req,
    input  logic ret,
    output logic crd_avl
`ifdef GEN_PIPE_SINK_ERR_EN
    ,
    output logic err_crd
`endif
);

    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam logic [CW-1:0] CRD_MAX = CW'(FIFO_DEPTH);

    logic [CW-1:0] crd_cnt;
    logic          take;

    assign crd_avl = (crd_cnt != '0);
    assign take    = take_req & crd_avl;

    // Simultaneous take and return cancel; the ceiling guards against stray returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crd_cnt <= CRD_MAX;
        end else if (take && !ret) begin
            crd_cnt <= crd_cnt - CW'(1);
        end else if (ret && !take && (crd_cnt != CRD_MAX)) begin
            crd_cnt <= crd_cnt + CW'(1);
        end
    end

`ifdef GEN_PIPE_SINK_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_crd <= 1'b0;
        end else if (take_req && !crd_avl) begin
            err_crd <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/gen_pipe_sink.sv
// Credit-based landing buffer behind a no-stall pipe, presenting beats to a ready/valid consumer.
// Latency 1: a beat pushed into an empty buffer shows on dat_out/vld_out the next cycle (no fall-through).
// Never stalls the pipe; upstream is throttled by crd_avl. GEN_PIPE_SINK_ERR_EN adds sticky err flags.
module gen_pipe_sink
    import gen_pipe_pkg::*;
#(
    parameter int DAT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             crd_avl,
    input  logic             crd_take,
    input  logic [DAT_W-1:0] dat_in,
    input  logic             vld_in,
    output logic [DAT_W-1:0] dat_out,
    output logic             vld_out,
    input  logic             rdy_in
`ifdef GEN_PIPE_SINK_ERR_EN
    ,
    output logic             err_ovf,
    output logic             err_crd
`endif
);

    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam logic [CW-1:0] OCC_FULL = CW'(FIFO_DEPTH);

    logic [DAT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;

    logic push;
    logic pop;
    logic full;
    logic wr_en;

    assign push  = vld_in;
    assign pop   = vld_out & rdy_in;
    assign full  = (occ == OCC_FULL);
    // A full buffer still accepts a beat when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);

    // Outputs depend only on flops, so nothing combinational reaches the consumer from dat_in.
    assign vld_out = (occ != '0);
    assign dat_out = vld_out ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= dat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
            end
            if (pop) begin
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
            end
            case ({wr_en, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef GEN_PIPE_SINK_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
        end else if (push && full && !pop) begin
            err_ovf <= 1'b1;
        end
    end
`endif

    gen_pipe_sink_crd #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_crd (
        .clk      (clk),
        .rst_n    (rst_n),
        .take_req (crd_take),
        .ret      (pop),
        .crd_avl  (crd_avl)
`ifdef GEN_PIPE_SINK_ERR_EN
        ,
        .err_crd  (err_crd)
`endif
    );

endmodule
